fixed_norm_div_seq: RTL
=======================

// Module: fixed_norm_div_seq
// PURPOSE
//  Multi-cycle signed FixedNorm divider (q = a / b), one quotient bit per clock (restoring).
//  Sits upstream of the combinational FixedNorm add/sub/mul/compare stage.
//  Supplies the normalised quotients that stage cannot form itself (reciprocals, ratio terms).
//  Valid/ready on both sides; one operation in flight.
// PARAMETERS
//  DATA_W  16  FixedNorm word width, two's complement
//  FRAC_W  14  fraction bits (1.0 = 1<<FRAC_W)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       synchronous, active-high
//  in_valid       in   1       operand pair valid
//  in_ready       out  1       block can accept operands
//  in_a           in   DATA_W  dividend, FixedNorm raw value
//  in_b           in   DATA_W  divisor, FixedNorm raw value
//  out_valid      out  1       result valid, held until accepted
//  out_ready      in   1       consumer accepts result
//  out_q          out  DATA_W  quotient, FixedNorm raw value
//  out_sat        out  1       magnitude clamped (overflow or div-by-zero)
//  out_dbz        out  1       divisor was zero
// BEHAVIOUR
//  Reset:
//   - outputs: in_ready=1, out_valid=0, out_q=0, out_sat=0, out_dbz=0.
//   - state=IDLE, counter=0.
//   - Reset mid-operation aborts it silently; the operation is never output.
//  FSM:
//   - IDLE: in_ready=1. On in_valid&in_ready, capture:
//     - sign = a[MSB]^b[MSB]
//     - |a|, |b| as unsigned DATA_W (0x8000 -> 32768)
//     - dividend = |a| << FRAC_W (N = DATA_W+FRAC_W bits)
//     - then go to RUN with cnt=N-1, or to DONE if b==0.
//   - RUN: in_ready=0. Each cycle: R = {R,dividend[cnt]}; if R >= |b| then R -= |b| and Q[cnt]=1.
//     At cnt==0, register the final result and go to DONE; otherwise cnt--.
//   - DONE: out_valid=1; out_q/out_sat/out_dbz stable. On out_ready go to IDLE, out_valid=0 next cycle.
//  Latency:
//   - Acceptance edge E0; out_valid rises at edge E0+N (30 for defaults).
//   - Divide-by-zero: out_valid rises at E0+1.
//   - Minimum acceptance-to-acceptance is N+1 cycles. No accept in the cycle a result is taken
//     (in_ready is high only in IDLE).
//  Arithmetic:
//   - Magnitude Q truncated toward zero, then negated if sign=1.
//   - If Q > 2^(DATA_W-1)-1: clamp to 0x7FFF (sign=0) or 0x8001 (sign=1), out_sat=1.
//     Symmetric clamp; 0x8000 is never produced.
//   - Division by zero: out_q = 0x7FFF if a>=0 else 0x8001; out_sat=1, out_dbz=1.
//     0/0 gives 0x7FFF, dbz=1.
//   - Zero dividend with b!=0 gives out_q=0, flags 0; the full N cycles still run.
//  Boundaries:
//   - in_a/in_b changes while not IDLE are ignored.
//   - in_valid held while busy is not consumed until IDLE.
//   - out_ready while out_valid=0 has no effect.
//   - Counter never wraps: RUN exits exactly at cnt==0.
//   - Flags are cleared on the next acceptance.
// TESTING (DATA_W=16, FRAC_W=14)
//  a=0x2000(0.5), b=0x4000(1.0) -> out_q=0x2000, sat=0, dbz=0, out_valid 30 cycles after accept
//  a=0xE000(-0.5), b=0x4000; then a=0x1000(0.25), b=0xC000(-1.0) -> 0xE000, then 0xF000
//  a=0x4000, b=0x2000 (=2.0, overflow) -> 0x7FFF, sat=1; a=0xC000, b=0x2000 -> 0x8001, sat=1
//  a=0x4000, b=0x0000 -> 0x7FFF, sat=1, dbz=1, out_valid 1 cycle after accept
//  hold out_ready=0 for 5 cycles in DONE, toggle in_a/in_b/in_valid -> out_q stable, in_ready=0;
//    result taken on the first out_ready=1 cycle
//  reset=1 at RUN cycle 10 -> next cycle in_ready=1, out_valid=0; the next op (0x2000/0x4000)
//    gives the correct 0x2000

Source files
------------

// File: rtl/fixed_norm_div_seq.sv
// fixed_norm_div_seq: multi-cycle signed FixedNorm restoring divider, one quotient bit per clock
module fixed_norm_div_seq #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_q,
    output logic              out_sat,
    output logic              out_dbz
);
    localparam int N  = DATA_W + FRAC_W;
    localparam int CW = $clog2(N);
    localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MAX = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [N-1:0]      d, q, q_nx;
    logic [DATA_W-1:0] a_mag_in, b_mag_in, b_mag, r, r_sh, r_nx, q_mag;
    logic              sign, dbz, ge, over, accept;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign a_mag_in  = in_a[DATA_W-1] ? -in_a : in_a;
    assign b_mag_in  = in_b[DATA_W-1] ? -in_b : in_b;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: accept in IDLE, leave RUN exactly at cnt==0, hold DONE until taken
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (accept ? RUN : IDLE)
                 : state == RUN  ? (cnt == '0 ? DONE : RUN)
                 : (out_ready ? IDLE : DONE);
    end

    // One restoring step; the partial remainder stays below |b| so DATA_W bits hold the shifted value
    always_comb begin
        r_sh  = (r << 1) | {{(DATA_W-1){1'b0}}, d[N-1]};
        ge    = r_sh >= b_mag;
        r_nx  = ge ? r_sh - b_mag : r_sh;
        q_nx  = (q << 1) | {{(N-1){1'b0}}, ge};
        over  = dbz || (q_nx > {{FRAC_W{1'b0}}, POS_MAX});
        q_mag = q_nx[DATA_W-1:0];
    end

    // Operand capture, iteration and result registration; divide-by-zero takes a single RUN pass
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            d       <= '0;
            q       <= '0;
            r       <= '0;
            b_mag   <= '0;
            sign    <= 1'b0;
            dbz     <= 1'b0;
            out_q   <= '0;
            out_sat <= 1'b0;
            out_dbz <= 1'b0;
        end else if (accept) begin
            sign    <= in_a[DATA_W-1] ^ in_b[DATA_W-1];
            b_mag   <= b_mag_in;
            d       <= {a_mag_in, {FRAC_W{1'b0}}};
            q       <= '0;
            r       <= '0;
            dbz     <= in_b == '0;
            cnt     <= in_b == '0 ? '0 : CW'(N-1);
            out_sat <= 1'b0;
            out_dbz <= 1'b0;
        end else if (state == RUN) begin
            d <= d << 1;
            r <= r_nx;
            q <= q_nx;
            if (cnt == '0) begin
                out_q   <= over ? (sign ? NEG_MAX : POS_MAX) : (sign ? -q_mag : q_mag);
                out_sat <= over;
                out_dbz <= dbz;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule
